// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: binary-to-BCD converter (sequential double-dabble) feeding a
// time-multiplexed 7-segment digit bus with active-low digit select.
// Handshake: load is a request that is honoured only in IDLE; busy is high
// while a conversion is in flight and done pulses for one cycle when the new
// digits are committed. There is no back-pressure and no queueing.
module led_scan_ctrl #(
   parameter int DIGITS  = 4,
   parameter int BIN_W   = 14,
   parameter int CLK_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BIN_W-1:0]  bin_in,
   input  logic              load,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [3:0]        digit_value,
   output logic [DIGITS-1:0] digit_sel,
   output logic [1:0]        dbg_state
);

   // One spare nibble above the displayed digits so an out-of-range value
   // leaves a visible non-zero nibble for the overflow check.
   localparam int NIB   = DIGITS + 1;
   localparam int BCD_W = 4 * NIB;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned MAX_VAL = 10**DIGITS - 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BIN_W-1:0]    r_bin;
   logic [BIN_W-1:0]    r_bin_cap;
   logic [BCD_W-1:0]    r_bcd;
   logic [BCD_W-1:0]    w_adj;
   logic [CNT_W-1:0]    r_bit;
   logic [4*DIGITS-1:0] r_disp;
   logic                r_ovf;
   logic                w_ovf;
   logic [DIV_W-1:0]    r_div;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic                w_wrap;
   logic [4*DIGITS-1:0] w_digits;
   logic                w_nz;
   logic [3:0]          r_val;
   logic [DIGITS-1:0]   r_sel;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next-state: IDLE -> SHIFT (BIN_W cycles) -> COMMIT (1 cycle) -> IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (load) w_state_nxt = S_SHIFT;
         S_SHIFT:  if (r_bit == CNT_W'(BIN_W - 1)) w_state_nxt = S_COMMIT;
         S_COMMIT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: busy covers SHIFT and COMMIT, done marks the commit cycle
   always_comb begin
      busy      = (r_state != S_IDLE);
      done      = (r_state == S_COMMIT);
      dbg_state = r_state;
   end

   // Add-3 correction of every BCD nibble that would reach >=10 after the shift
   always_comb begin
      w_adj = r_bcd;
      for (int n = 0; n < NIB; n++) begin
         if (r_bcd[4*n +: 4] >= 4'd5) w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
      end
   end

   // Overflow: spare nibble set, or value too large even for the spare nibble
   always_comb begin
      w_ovf = (r_bcd[BCD_W-1 -: 4] != 4'd0) || (32'(r_bin_cap) > MAX_VAL);
   end

   // Conversion datapath and committed display register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin     <= '0;
         r_bin_cap <= '0;
         r_bcd     <= '0;
         r_bit     <= '0;
         r_disp    <= '0;
         r_ovf     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (load) begin
                  r_bin     <= bin_in;
                  r_bin_cap <= bin_in;
                  r_bcd     <= '0;
                  r_bit     <= '0;
               end
            end
            S_SHIFT: begin
               {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
               r_bit          <= r_bit + CNT_W'(1);
            end
            S_COMMIT: begin
               r_disp <= r_bcd[4*DIGITS-1:0];
               r_ovf  <= w_ovf;
            end
            default: ;
         endcase
      end
   end

   // Per-digit display value with overflow blanking and leading-zero blanking
   always_comb begin
      w_digits = '1;
      w_nz     = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if (r_disp[4*k +: 4] != 4'd0) w_nz = 1'b1;
         if (r_ovf)                    w_digits[4*k +: 4] = 4'hF;
         else if (k != 0 && !w_nz)     w_digits[4*k +: 4] = 4'hF;
         else                          w_digits[4*k +: 4] = r_disp[4*k +: 4];
      end
   end

   // Next scan index: advances only when the dwell divider wraps
   always_comb begin
      w_wrap    = (r_div == DIV_W'(CLK_DIV - 1));
      w_idx_nxt = r_idx;
      if (w_wrap) w_idx_nxt = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
   end

   // Free-running dwell divider and scan index
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div <= '0;
         r_idx <= '0;
      end else begin
         r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
         r_idx <= w_idx_nxt;
      end
   end

   // Registered digit bus: select and value always change on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel <= ~DIGITS'(1);
         r_val <= 4'd0;
      end else begin
         r_sel <= ~(DIGITS'(1) << w_idx_nxt);
         r_val <= w_digits[4*w_idx_nxt +: 4];
      end
   end

   assign overflow    = r_ovf;
   assign digit_value = r_val;
   assign digit_sel   = r_sel;

endmodule
